// File: rtl/ram_capture_writer.sv
// Triggered capture controller: arms on start, waits for a rising crossing of
// trig_level, then streams 2**ADDRESS_WIDTH valid samples into the RAM write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | inactive; waits for start
// ARMED   | watching the sample stream for a rising crossing of trig_level
// CAPTURE | writing each valid sample to the next RAM address
// DONE    | buffer full; holds until start rearms
module ram_capture_writer #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    sample_in,
    input  logic                     sample_valid,
    input  logic [DATA_WIDTH-1:0]    trig_level,
    input  logic                     start,
    input  logic                     abort,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    din,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   wr_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = '1;

    state_t                   state, state_next;
    logic [DATA_WIDTH-1:0]    prev;
    logic                     prev_ok;
    logic [ADDRESS_WIDTH-1:0] addr_cnt;
    logic                     trigger;
    logic                     do_write;
    logic                     arm_entry;

    assign trigger = sample_valid & prev_ok & (prev < trig_level) & (sample_in >= trig_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        arm_entry  = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_ARMED;
                        arm_entry  = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (trigger) begin
                        do_write   = 1'b1;
                        state_next = (addr_cnt == ADDR_LAST) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid) begin
                        do_write = 1'b1;
                        if (addr_cnt == ADDR_LAST) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_next = S_ARMED;
                        arm_entry  = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // prev/prev_ok track the stream in every state; arming forgets the history
    // so a crossing must be seen entirely after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            din      <= '0;
            wr_count <= '0;
            addr_cnt <= '0;
            prev     <= '0;
            prev_ok  <= 1'b0;
        end else begin
            wr_en <= do_write;
            if (sample_valid) begin
                prev    <= sample_in;
                prev_ok <= 1'b1;
            end
            if (arm_entry) begin
                prev_ok  <= 1'b0;
                addr_cnt <= '0;
                wr_count <= '0;
            end
            if (do_write) begin
                wr_addr  <= addr_cnt;
                din      <= sample_in;
                addr_cnt <= addr_cnt + 1'b1;
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    assign busy = (state == S_ARMED) || (state == S_CAPTURE);
    assign done = (state == S_DONE);

endmodule

// File: doc/ram_capture_writer.md
# ram_capture_writer

Triggered sample-capture controller that fills the signal-generator dual-port RAM through its write port (`wr_en`, `wr_addr`, `din`). It arms on command, waits for a rising crossing of a programmable level on the incoming sample stream, then writes exactly 2**ADDRESS_WIDTH consecutive valid samples to addresses 0 upward. It stops and flags completion so the read side can play the buffer back.

## Interface
- `ADDRESS_WIDTH`, default 9: RAM address width; capture depth is 2**ADDRESS_WIDTH.
- `DATA_WIDTH`, default 8: sample and RAM word width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_in`  in  DATA_WIDTH  incoming sample, unsigned.
- `sample_valid`  in  1  `sample_in` is valid this cycle (one sample per asserted cycle).
- `trig_level`  in  DATA_WIDTH  trigger threshold, unsigned; sampled each use, not latched.
- `start`  in  1  arm request, level-sensitive, acted on per cycle.
- `abort`  in  1  return to IDLE immediately.
- `wr_en`  out  1  RAM write enable, registered.
- `wr_addr`  out  ADDRESS_WIDTH  RAM write address, registered.
- `din`  out  DATA_WIDTH  RAM write data, registered.
- `busy`  out  1  high in ARMED or CAPTURE.
- `done`  out  1  capture complete.
- `wr_count`  out  ADDRESS_WIDTH+1  samples written in the current or last capture.

## Operation
- States:
  - IDLE → ARMED when `start`=1.
  - ARMED → CAPTURE on the trigger sample.
  - CAPTURE → DONE on the edge that registers the write to address 2**ADDRESS_WIDTH−1.
  - DONE → ARMED when `start`=1; DONE holds otherwise.
- `abort`=1 forces IDLE from any state. Priority: `abort` over `start`.
- `start` is ignored in ARMED and CAPTURE.
- Trigger detection:
  - Register `prev` holds the previous valid sample. Flag `prev_ok` is set by any valid sample and cleared on entry to ARMED.
  - Trigger is `sample_valid & prev_ok & (prev < trig_level) & (sample_in >= trig_level)`, evaluated only in ARMED.
  - `prev`/`prev_ok` update on every valid sample in every state.
- Writing:
  - The trigger sample itself is written to address 0.
  - Each further valid sample in CAPTURE is written to the next address.
  - Cycles without `sample_valid` produce no write; the address does not advance.
- Address counter:
  - ADDRESS_WIDTH bits; cleared to 0 on entry to ARMED.
  - Never wraps within one capture. After 2**ADDRESS_WIDTH writes the FSM leaves CAPTURE, so the counter's wrap to 0 is not visible as a write.
- `wr_count`:
  - Cleared to 0 on entry to ARMED; increments with each registered write.
  - Reads 2**ADDRESS_WIDTH in DONE.
  - Holds its value in IDLE after an abort.
- `busy`/`done` are decoded from registered state: `busy` = ARMED|CAPTURE, `done` = DONE.

## Timing
- Reset values: state IDLE; `wr_en` 0, `wr_addr` 0, `din` 0, `busy` 0, `done` 0, `wr_count` 0; `prev` 0, `prev_ok` 0.
- Write latency is 1 cycle. For a valid sample accepted at edge k, `wr_en`=1 with its `wr_addr`/`din` during cycle k..k+1, i.e. visible after edge k.
- `wr_en` is a single-cycle pulse per sample. Back-to-back valid samples give back-to-back writes.
- `done` rises in the same cycle as the final `wr_en` pulse (address 2**ADDRESS_WIDTH−1). `busy` falls in that same cycle.
- `start` → `busy`=1 one cycle later.
- Earliest trigger is the second valid sample after arming, because `prev_ok` must be set first.
- Abort at edge k:
  - No write is registered at edge k; `wr_en`=0 after edge k.
  - State becomes IDLE.
  - RAM contents already written are left in place.
- `rst_n` low mid-capture: all outputs go to reset values immediately, asynchronously. A pending write is dropped.
- `trig_level` equal to 0: no trigger is possible because `prev` < 0 is never true; the block stays ARMED.
- `trig_level` at maximum: triggers only on a transition from below max to exactly max.

## Test plan
All scenarios use ADDRESS_WIDTH=3, DATA_WIDTH=8.
- **Reset:** assert `rst_n`=0 mid-CAPTURE → all outputs 0 within the same cycle; after release, state is IDLE and `busy`=0.
- **Basic capture:** `trig_level`=0x80, `start` pulse, then a valid ramp 0x70, 0x78, 0x80, 0x88 … step 8 → writes of 0x80..0xB8 at addresses 0..7, one per cycle. `done`=1 with the addr-7 write, `wr_count`=8, then no further `wr_en`.
- **Gapped valid:** same as basic capture with `sample_valid` toggling 1,0,1,0 → 8 writes, addresses contiguous 0..7, no `wr_en` in the gap cycles.
- **No false trigger:** samples 0x90, 0x95, 0x7F, 0x80 with level 0x80 → the first sample is not a trigger (no `prev`), 0x90→0x95 is not a trigger, 0x7F→0x80 triggers; 0x80 is written at addr 0.
- **Abort/rearm:** abort after the 3rd write → `wr_en` 0 next cycle, IDLE, `wr_count`=3. A subsequent `start` rearms, `wr_count`=0, and the next capture restarts at addr 0.
- **Simultaneous/ignored:** `start`+`abort` in IDLE → stays IDLE. `start` in CAPTURE → ignored, capture completes normally. `start` in DONE → ARMED, `done`=0 next cycle.
